db_req_arb: RTL and testbench
=============================

Name: db_req_arb

Overview:
- Two-requester arbiter and sequencer in front of the key/flag lookup engine (db_top).
- Requester 0 is the network RX lookup path; requester 1 is the control/insert path.
- Grants requests round-robin and enforces the engine's minimum inter-request gap (the CRC hash must clear between keys).
- Tracks outstanding requests in an in-order tag FIFO and routes each engine response back to the requester that issued it.

Parameters:
- KEY_SIZE, 96, key width in bits.
- FLAG_SIZE, 4, op/flag width in bits.
- MAX_OUT, 8, maximum outstanding requests (tag FIFO depth); must be a power of 2, >= 2.
- ISSUE_GAP, 2, idle cycles forced after each issued request before the next issue.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-low (rst==0 resets).
- r0_key, in, KEY_SIZE, requester 0 key.
- r0_flag, in, FLAG_SIZE, requester 0 op.
- r0_valid, in, 1, requester 0 request valid.
- r0_ready, out, 1, requester 0 accepted this cycle.
- r0_rsp_valid, out, 1, response pulse to requester 0.
- r0_rsp_flag, out, FLAG_SIZE, response flag to requester 0.
- r1_key / r1_flag / r1_valid / r1_ready / r1_rsp_valid / r1_rsp_flag: same as r0_*, for requester 1.
- db_key, out, KEY_SIZE, key to engine.
- db_flag, out, FLAG_SIZE, op to engine.
- db_valid, out, 1, one-cycle request strobe to engine.
- db_out_valid, in, 1, engine response strobe.
- db_out_flag, in, FLAG_SIZE, engine response flag.
- outstanding, out, $clog2(MAX_OUT)+1, current in-flight count.
- err_orphan, out, 1, sticky: engine response arrived with no outstanding tag.

Behaviour:
- Reset (rst==0 at a clk edge) clears all of the following:
  - Outputs: db_valid, db_key, db_flag, rN_rsp_valid, rN_rsp_flag, outstanding, err_orphan all go to 0.
  - State: FSM goes to IDLE, the round-robin pointer is set to favour r0 first, the gap counter is 0, and the FIFO pointers are 0.
  - Reset mid-operation discards in-flight tags. Responses arriving after reset are treated as orphans.
- FSM has two states:
  - IDLE: may grant. On a grant, go to GAP and load the gap counter with ISSUE_GAP.
  - GAP: counter decrements each cycle. At 0, return to IDLE. With ISSUE_GAP==0, IDLE is never left.
- Grant (combinational, in IDLE only) requires outstanding < MAX_OUT.
  - Only one rN_valid set: grant it.
  - Both set: grant the requester not granted last. The pointer toggles only on a grant.
  - rN_ready = grant to N. A handshake is rN_valid & rN_ready.
  - Requesters must hold key/flag/valid stable until ready.
- Issue: on the cycle after a handshake, db_valid=1 for exactly one cycle, with db_key/db_flag registered from the granted requester.
  - The requester ID is pushed into the tag FIFO on that same registered cycle.
  - Minimum spacing between db_valid pulses is ISSUE_GAP+1 cycles.
- Response: db_out_valid with a non-empty FIFO pops the head tag.
  - Next cycle, rT_rsp_valid=1 for one cycle with rT_rsp_flag=db_out_flag. The other rsp_valid stays 0.
  - Responses have no backpressure; requesters must always sink them.
  - rN_rsp_flag holds its last value while rsp_valid is 0.
- Orphan response: db_out_valid with an empty FIFO (outstanding==0) sets err_orphan until reset.
  - No rsp_valid is raised and the FIFO is unchanged.
- outstanding update:
  - +1 on push, -1 on pop.
  - Simultaneous push and pop leaves it unchanged.
  - A push and pop in the same cycle at MAX_OUT-1 or at 1 is legal.
  - It never exceeds MAX_OUT, because grant is blocked at full.
- Full: at outstanding==MAX_OUT both readys are 0. Grant is re-enabled the cycle after a pop.
- FIFO pointers are $clog2(MAX_OUT) bits and wrap modulo MAX_OUT.
- Ordering: the engine is in-order and fixed-latency, so responses map strictly FIFO.

Test Plan:
- Single request: r0 issues key=96'h0A000001_0A000002_1F900000, flag=4'h1.
  - Expect r0_ready in cycle 0 and db_valid in cycle 1 with the same key/flag.
  - Engine responds flag=4'h2 → expect r0_rsp_valid with r0_rsp_flag=4'h2 one cycle later; r1_rsp_valid stays 0.
- Contention: r0_valid and r1_valid held high from reset for 6 grants with ISSUE_GAP=2.
  - Expect grant order r0,r1,r0,r1,r0,r1.
  - db_valid pulses exactly 3 cycles apart.
  - Tag FIFO contents are 0,1,0,1,0,1.
- Full: MAX_OUT=8 with no responses. After 8 issues, outstanding=8 and both readys are 0 for 20 cycles.
  - One response → outstanding=7 and a new grant occurs in IDLE.
- Simultaneous push/pop: with outstanding=3, a db_out_valid coincides with a push.
  - Expect outstanding stays 3.
  - Response routed to the oldest tag.
  - Pointers wrap correctly after 20 round-trips.
- Orphan: after reset, pulse db_out_valid with flag=4'h3.
  - Expect err_orphan=1 from the next cycle onward, no rsp_valid, outstanding=0.
  - err_orphan is cleared only by rst=0.
- Reset mid-flight: issue 3 requests, assert rst=0 for 1 cycle.
  - Expect all outputs 0, outstanding=0.
  - A later engine response sets err_orphan.
  - Arbitration restarts with r0 favoured.

Source files
------------

// File: rtl/db_req_arb.sv
// rtl/db_req_arb.sv - two-requester round-robin arbiter and in-order response router for db_top
module db_req_arb #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int MAX_OUT   = 8,
  parameter int ISSUE_GAP = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KEY_SIZE-1:0]          r0_key,
  input  logic [FLAG_SIZE-1:0]         r0_flag,
  input  logic                         r0_valid,
  output logic                         r0_ready,
  output logic                         r0_rsp_valid,
  output logic [FLAG_SIZE-1:0]         r0_rsp_flag,
  input  logic [KEY_SIZE-1:0]          r1_key,
  input  logic [FLAG_SIZE-1:0]         r1_flag,
  input  logic                         r1_valid,
  output logic                         r1_ready,
  output logic                         r1_rsp_valid,
  output logic [FLAG_SIZE-1:0]         r1_rsp_flag,
  output logic [KEY_SIZE-1:0]          db_key,
  output logic [FLAG_SIZE-1:0]         db_flag,
  output logic                         db_valid,
  input  logic                         db_out_valid,
  input  logic [FLAG_SIZE-1:0]         db_out_flag,
  output logic [$clog2(MAX_OUT):0]     outstanding,
  output logic                         err_orphan
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam int GW = (ISSUE_GAP < 1) ? 1 : $clog2(ISSUE_GAP + 1);

  typedef enum logic {IDLE, GAP} state_t;

  state_t          state;
  logic [GW-1:0]   gap_cnt;
  logic            last_gnt;   // 1 means r1 was granted last, so r0 wins the next tie
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            tag_mem [MAX_OUT];
  logic            can_grant;
  logic            gnt0;
  logic            gnt1;
  logic            push;
  logic            pop;
  logic            head_tag;

  // Grant decision: only in IDLE with room in the tag FIFO, ties go to the requester not served last
  always_comb begin
    can_grant = (state == IDLE) && (outstanding < CW'(MAX_OUT));
    gnt0      = can_grant && r0_valid && (!r1_valid || last_gnt);
    gnt1      = can_grant && r1_valid && (!r0_valid || !last_gnt);
    push      = gnt0 || gnt1;
    pop       = db_out_valid && (outstanding != '0);
    head_tag  = tag_mem[rd_ptr];
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  // Issue-gap sequencer and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            last_gnt <= gnt1;
            if (ISSUE_GAP != 0) begin
              state   <= GAP;
              gap_cnt <= GW'(ISSUE_GAP);
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register the granted request into a one-cycle engine strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_valid <= 1'b0;
      db_key   <= '0;
      db_flag  <= '0;
    end else begin
      db_valid <= push;
      if (push) begin
        db_key  <= gnt1 ? r1_key  : r0_key;
        db_flag <= gnt1 ? r1_flag : r0_flag;
      end
    end
  end

  // Tag storage: requester id of each issued request, oldest at rd_ptr
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= gnt1;
    end
  end

  // Tag FIFO pointers and in-flight count
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        outstanding <= outstanding + CW'(1);
      end else if (pop && !push) begin
        outstanding <= outstanding - CW'(1);
      end
    end
  end

  // Route each engine response to the requester that owns the oldest tag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rsp_flag  <= '0;
      r1_rsp_flag  <= '0;
    end else begin
      r0_rsp_valid <= pop && !head_tag;
      r1_rsp_valid <= pop && head_tag;
      if (pop && !head_tag) begin
        r0_rsp_flag <= db_out_flag;
      end
      if (pop && head_tag) begin
        r1_rsp_flag <= db_out_flag;
      end
    end
  end

  // Sticky flag for engine responses that have no tag to match
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_orphan <= 1'b0;
    end else if (db_out_valid && (outstanding == '0)) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_db_req_arb.sv
// tb/tb_db_req_arb.sv - randomized scoreboard bench for db_req_arb
module tb_db_req_arb;

  localparam int KS  = 96;
  localparam int FS  = 4;
  localparam int MO  = 8;
  localparam int GAP = 2;
  localparam int CW  = $clog2(MO) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [KS-1:0]  r0_key, r1_key;
  logic [FS-1:0]  r0_flag, r1_flag;
  logic           r0_valid, r1_valid;
  logic           r0_ready, r1_ready;
  logic           r0_rsp_valid, r1_rsp_valid;
  logic [FS-1:0]  r0_rsp_flag, r1_rsp_flag;
  logic [KS-1:0]  db_key;
  logic [FS-1:0]  db_flag;
  logic           db_valid;
  logic           db_out_valid;
  logic [FS-1:0]  db_out_flag;
  logic [CW-1:0]  outstanding;
  logic           err_orphan;

  always #5 clk = ~clk;

  db_req_arb #(.KEY_SIZE(KS), .FLAG_SIZE(FS), .MAX_OUT(MO), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .r0_key(r0_key), .r0_flag(r0_flag), .r0_valid(r0_valid), .r0_ready(r0_ready),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_flag(r0_rsp_flag),
    .r1_key(r1_key), .r1_flag(r1_flag), .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_flag(r1_rsp_flag),
    .db_key(db_key), .db_flag(db_flag), .db_valid(db_valid),
    .db_out_valid(db_out_valid), .db_out_flag(db_out_flag),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct { logic [KS-1:0] key; logic [FS-1:0] flag; } iss_t;
  typedef struct { bit id; logic [FS-1:0] flag; } rsp_t;
  typedef struct { int due; logic [FS-1:0] flag; } eng_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight list of requester ids, gap measured in cycles since last grant
  int            m_cnt;
  bit            m_last;
  int            m_since;
  bit            m_err;
  bit            tags[$];
  iss_t          iss_q[$];
  rsp_t          rsp_q[$];
  logic [FS-1:0] m_rflag [2];
  bit            chk_rst;

  always @(negedge clk) begin : monitor
    bit   g0, g1, ok;
    iss_t ie;
    rsp_t re;
    if (rst !== 1'b1) begin
      m_cnt = 0; m_last = 1'b1; m_since = 1000; m_err = 1'b0;
      tags.delete(); iss_q.delete(); rsp_q.delete();
      m_rflag[0] = '0; m_rflag[1] = '0;
      chk_rst = 1'b1;
    end else begin
      if (chk_rst) begin
        check("rst_db_key", db_key, '0);
        check("rst_db_flag", db_flag, '0);
        chk_rst = 1'b0;
      end
      check("outstanding", outstanding, m_cnt);
      check("err_orphan", err_orphan, m_err);
      if (iss_q.size() != 0) begin
        ie = iss_q.pop_front();
        check("db_valid", db_valid, 1'b1);
        check("db_key", db_key, ie.key);
        check("db_flag", db_flag, ie.flag);
      end else begin
        check("db_valid_idle", db_valid, 1'b0);
      end
      if (rsp_q.size() != 0) begin
        re = rsp_q.pop_front();
        m_rflag[re.id] = re.flag;
        check("r0_rsp_valid", r0_rsp_valid, re.id == 1'b0);
        check("r1_rsp_valid", r1_rsp_valid, re.id == 1'b1);
      end else begin
        check("r0_rsp_valid_idle", r0_rsp_valid, 1'b0);
        check("r1_rsp_valid_idle", r1_rsp_valid, 1'b0);
      end
      check("r0_rsp_flag", r0_rsp_flag, m_rflag[0]);
      check("r1_rsp_flag", r1_rsp_flag, m_rflag[1]);
      ok = (m_since > GAP) && (m_cnt < MO);
      g0 = ok && (r0_valid === 1'b1) && ((r1_valid !== 1'b1) || m_last);
      g1 = ok && (r1_valid === 1'b1) && ((r0_valid !== 1'b1) || !m_last);
      check("r0_ready", r0_ready, g0);
      check("r1_ready", r1_ready, g1);
      if (db_out_valid === 1'b1) begin
        if (tags.size() != 0) begin
          re.id   = tags.pop_front();
          re.flag = db_out_flag;
          rsp_q.push_back(re);
          m_cnt--;
        end else begin
          m_err = 1'b1;
        end
      end
      if (g0 || g1) begin
        ie.key  = g1 ? r1_key : r0_key;
        ie.flag = g1 ? r1_flag : r0_flag;
        iss_q.push_back(ie);
        tags.push_back(g1);
        m_last  = g1;
        m_since = 0;
        m_cnt++;
      end
      if (m_since < 1000) m_since++;
    end
  end

  // Stimulus: two requesters honouring valid/ready and a fixed-latency in-order engine
  bit   eng_en;
  int   lat;
  int   p0, p1;
  int   n_new, limit;
  int   cyc;
  eng_t eq[$];

  task automatic step();
    bit            h0, h1, dv;
    logic [FS-1:0] df;
    eng_t          e;
    @(negedge clk);
    h0 = rst && r0_valid && r0_ready;
    h1 = rst && r1_valid && r1_ready;
    dv = rst && db_valid;
    df = db_flag;
    @(posedge clk);
    #1;
    cyc++;
    if (dv) begin
      e.due  = cyc + lat;
      e.flag = df ^ 4'h3;
      eq.push_back(e);
    end
    db_out_valid = 1'b0;
    if (eng_en && eq.size() != 0 && eq[0].due <= cyc) begin
      e = eq.pop_front();
      db_out_valid = 1'b1;
      db_out_flag  = e.flag;
    end
    if (h0) r0_valid = 1'b0;
    if (h1) r1_valid = 1'b0;
    if (!r0_valid && n_new < limit && $urandom_range(99) < p0) begin
      r0_key = {$urandom, $urandom, $urandom}; r0_flag = FS'($urandom); r0_valid = 1'b1; n_new++;
    end
    if (!r1_valid && n_new < limit && $urandom_range(99) < p1) begin
      r1_key = {$urandom, $urandom, $urandom}; r1_flag = FS'($urandom); r1_valid = 1'b1; n_new++;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; r0_key = '0; r1_key = '0;
    r0_flag = '0; r1_flag = '0; db_out_valid = 1'b0; db_out_flag = '0;
    eng_en = 1'b1; lat = 2; p0 = 0; p1 = 0; n_new = 0; limit = 0; cyc = 0;
    repeat (3) step();
    rst = 1'b1;

    // single request, engine answers flag 1 ^ 3 = 2
    r0_key = 96'h0A000001_0A000002_1F900000; r0_flag = 4'h1; r0_valid = 1'b1;
    repeat (10) step();

    // contention from reset: six alternating grants
    p0 = 100; p1 = 100; limit = n_new + 6; lat = 5;
    reset_dut();
    repeat (40) step();

    // full: no responses until both readys stay low, then let the engine drain
    eng_en = 1'b0; limit = n_new + 1000;
    repeat (60) step();
    eng_en = 1'b1;
    repeat (60) step();

    // randomized traffic with varying latency and request rates
    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(1, 12);
      p0  = $urandom_range(10, 100);
      p1  = $urandom_range(10, 100);
      repeat (200) step();
    end
    p0 = 0; p1 = 0;
    repeat (60) step();

    // orphan response after reset
    reset_dut();
    db_out_valid = 1'b1; db_out_flag = 4'h3;
    step();
    repeat (6) step();

    // reset mid-flight: responses to pre-reset requests become orphans, r0 favoured again
    reset_dut();
    eng_en = 1'b0; p0 = 100; limit = n_new + 3;
    repeat (15) step();
    p0 = 0;
    reset_dut();
    eng_en = 1'b1;
    repeat (20) step();
    p0 = 100; p1 = 100; limit = n_new + 8; lat = 3;
    repeat (40) step();
    p0 = 0; p1 = 0;
    repeat (30) step();

    check("engine_drained", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
